// File: rtl/count_ones_seq.sv
// Sequential population counter: accepts a word over valid/ready, counts ones (or zeros)
// a chunk of BITS_PER_CYCLE bits per cycle, stops early, and holds the result until taken.
module count_ones_seq #(
  parameter int WORD_SIZE      = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int COUNT_SIZE     = $clog2(WORD_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_SIZE-1:0]  data,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  start,
  output logic                  busy,
  output logic [COUNT_SIZE-1:0] bit_count,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [WORD_SIZE-1:0]  temp;
  logic [WORD_SIZE-1:0]  captured;
  logic [WORD_SIZE-1:0]  temp_shifted;
  logic [COUNT_SIZE-1:0] chunk_ones;
  logic                  first_shift;
  logic                  out_valid_q;

  // Zero counting works on the inverted word, so early termination serves both modes.
  assign captured     = mode ? ~data : data;
  assign temp_shifted = temp >> BITS_PER_CYCLE;

  always_comb begin
    chunk_ones = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      chunk_ones = chunk_ones + COUNT_SIZE'(temp[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (captured == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        start = first_shift;
        if (temp_shifted == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // out_valid is registered, so it rises one cycle after DONE is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      temp        <= '0;
      bit_count   <= '0;
      first_shift <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            temp        <= captured;
            bit_count   <= '0;
            first_shift <= (captured != '0);
          end
        end
        SHIFT: begin
          bit_count   <= bit_count + chunk_ones;
          temp        <= temp_shifted;
          first_shift <= 1'b0;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_count_ones_seq.sv
// Scoreboard bench for count_ones_seq: one BITS_PER_CYCLE=1 and one BITS_PER_CYCLE=4 instance
// sharing inputs; sel chooses which instance is driven and observed.
module tb_count_ones_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       mode;
  logic       in_valid;
  logic       out_ready;
  logic       sel;

  logic       in_valid1, in_ready1, start1, busy1, out_valid1;
  logic       in_valid4, in_ready4, start4, busy4, out_valid4;
  logic [3:0] bit_count1, bit_count4;

  logic       o_in_ready, o_start, o_busy, o_out_valid;
  logic [3:0] o_bit_count;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  assign in_valid1   = in_valid & ~sel;
  assign in_valid4   = in_valid & sel;
  assign o_in_ready  = sel ? in_ready4  : in_ready1;
  assign o_start     = sel ? start4     : start1;
  assign o_busy      = sel ? busy4      : busy1;
  assign o_out_valid = sel ? out_valid4 : out_valid1;
  assign o_bit_count = sel ? bit_count4 : bit_count1;

  count_ones_seq #(.WORD_SIZE(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .data(data), .mode(mode), .in_valid(in_valid1),
    .in_ready(in_ready1), .start(start1), .busy(busy1), .bit_count(bit_count1),
    .out_valid(out_valid1), .out_ready(out_ready)
  );

  count_ones_seq #(.WORD_SIZE(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .data(data), .mode(mode), .in_valid(in_valid4),
    .in_ready(in_ready4), .start(start4), .busy(busy4), .bit_count(bit_count4),
    .out_valid(out_valid4), .out_ready(out_ready)
  );

  function automatic logic [3:0] model_count(input logic [7:0] d, input logic m);
    logic [7:0] t;
    logic [3:0] n;
    t = m ? ~d : d;
    n = 0;
    for (int i = 0; i < 8; i++) if (t[i]) n++;
    return n;
  endfunction

  function automatic int model_shifts(input logic [7:0] d, input logic m, input int bpc);
    logic [7:0] t;
    int h;
    t = m ? ~d : d;
    if (t == 8'h00) return 0;
    h = 0;
    for (int i = 0; i < 8; i++) if (t[i]) h = i;
    return h / bpc + 1;
  endfunction

  // Offers one word, measures SHIFT length and latency, then stalls the consumer and takes the result.
  task automatic run_word(input logic [7:0] d, input logic m, input int bpc, input int stall);
    logic [3:0] exp_cnt, got;
    int exp_n, k, shifts, starts, bad_start;
    exp_cnt = model_count(d, m);
    exp_n   = model_shifts(d, m, bpc);
    @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL in_ready_before_accept got %b want 1", o_in_ready);
    end
    data = d; mode = m; in_valid = 1'b1;
    exp_q.push_back(exp_cnt);
    @(negedge clk);
    in_valid = 1'b0;
    data = 8'($urandom);
    mode = 1'($urandom);
    k = 0; shifts = 0; starts = 0; bad_start = 0;
    while (o_out_valid !== 1'b1 && k < 40) begin
      if (o_busy === 1'b1) shifts++;
      if (o_start === 1'b1) begin
        starts++;
        if (!(o_busy === 1'b1 && shifts == 1)) bad_start = 1;
      end
      k++;
      @(negedge clk);
    end
    checks++;
    if (k != exp_n + 1) begin
      errors++;
      $display("[TB] FAIL latency word=%h mode=%b got %0d want %0d", d, m, k, exp_n + 1);
    end
    checks++;
    if (shifts != exp_n || starts != (exp_n > 0 ? 1 : 0) || bad_start != 0) begin
      errors++;
      $display("[TB] FAIL shift_start word=%h got busy=%0d starts=%0d misplaced=%0d want busy=%0d starts=%0d",
               d, shifts, starts, bad_start, exp_n, (exp_n > 0 ? 1 : 0));
    end
    got = 4'hx;
    if (exp_q.size() > 0) got = exp_q.pop_front();
    checks++;
    if (o_bit_count !== got) begin
      errors++;
      $display("[TB] FAIL bit_count word=%h mode=%b got %0d want %0d", d, m, o_bit_count, got);
    end
    for (int i = 0; i < stall; i++) begin
      data = 8'hFF; mode = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (o_out_valid !== 1'b1 || o_bit_count !== got || o_in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure cycle %0d got valid=%b count=%0d in_ready=%b want 1 %0d 0",
                 i, o_out_valid, o_bit_count, o_in_ready, got);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_bit_count !== got) begin
      errors++;
      $display("[TB] FAIL take_result got valid=%b in_ready=%b busy=%b count=%0d want 0 1 0 %0d",
               o_out_valid, o_in_ready, o_busy, o_bit_count, got);
    end
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (o_out_valid !== 1'b1 && k < 40) begin
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_start !== 1'b0 ||
        o_out_valid !== 1'b0 || o_bit_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got rdy=%b busy=%b start=%b valid=%b count=%0d want 1 0 0 0 0",
               o_in_ready, o_busy, o_start, o_out_valid, o_bit_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_word(8'hB5, 1'b0, 1, 0);
    run_word(8'h03, 1'b0, 1, 0);
    run_word(8'h00, 1'b0, 1, 0);
    run_word(8'hF0, 1'b1, 1, 0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    run_word(8'hB5, 1'b0, 1, 5);
  endtask

  task automatic test_reset_mid_shift();
    sel = 1'b0;
    @(negedge clk);
    data = 8'hFF; mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_bit_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_shift got rdy=%b busy=%b valid=%b count=%0d want 1 0 0 0",
               o_in_ready, o_busy, o_out_valid, o_bit_count);
    end
    run_word(8'h81, 1'b0, 1, 0);
  endtask

  // A word offered in the same cycle the result is taken must wait for the following IDLE cycle.
  task automatic test_take_and_offer();
    int k;
    logic [3:0] got;
    sel = 1'b0;
    @(negedge clk);
    data = 8'h03; mode = 1'b0; in_valid = 1'b1;
    exp_q.push_back(model_count(8'h03, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(k);
    got = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    checks++;
    if (o_out_valid !== 1'b1 || o_bit_count !== got) begin
      errors++;
      $display("[TB] FAIL first_result got valid=%b count=%0d want 1 %0d", o_out_valid, o_bit_count, got);
    end
    data = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL offer_during_take got rdy=%b busy=%b want 1 0", o_in_ready, o_busy);
    end
    exp_q.push_back(model_count(8'h0F, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_after_take got busy=%b start=%b want 1 1", o_busy, o_start);
    end
    wait_valid(k);
    got = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    checks++;
    if (o_out_valid !== 1'b1 || o_bit_count !== got) begin
      errors++;
      $display("[TB] FAIL second_result got valid=%b count=%0d want 1 %0d", o_out_valid, o_bit_count, got);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_word(8'($urandom), 1'($urandom), 1, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_wide_chunk();
    sel = 1'b1;
    run_word(8'hFF, 1'b0, 4, 0);
    run_word(8'h01, 1'b0, 4, 0);
    run_word(8'hFF, 1'b1, 4, 0);
    run_word(8'h5A, 1'b1, 4, 1);
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b0; data = 8'h00; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    $display("[TB] starting count_ones_seq bench");
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_shift();
    test_take_and_offer();
    test_back_to_back();
    test_wide_chunk();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
